// File: rtl/overall.sv
`timescale 1ns/1ps
// Single-block SHA-256 core: hashes one pre-padded 512-bit block starting
// from the standard initial hash values, one compression round per cycle.
// Ports:
//   clk       - rising-edge clock
//   reset     - asynchronous active-low reset; release starts a new hash
//   message   - pre-padded block, bit 0 = MSB of W0, W[i] = message[32i +: 32]
//   ready     - high once hashvalue holds the finished digest
//   hashvalue - digest, H0 at [255:224] down to H7 at [31:0]
module overall (
  input  logic         clk,
  input  logic         reset,
  input  logic [0:511] message,
  output logic         ready,
  output logic [255:0] hashvalue
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 6;

  localparam logic [WORD_W-1:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [WORD_W-1:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {LOAD, ROUND, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WORD_W-1:0]  w [16];
  logic [WORD_W-1:0]  a, b, c, d, e, f, g, h;
  logic [WORD_W-1:0]  t1_c, t2_c, w_next_c;

  function automatic logic [WORD_W-1:0] bsig0(input logic [WORD_W-1:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [WORD_W-1:0] bsig1(input logic [WORD_W-1:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [WORD_W-1:0] ssig0(input logic [WORD_W-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [WORD_W-1:0] ssig1(input logic [WORD_W-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  // Round datapath; w[0] is always W[t] for the current round.
  always_comb begin
    t1_c     = h + bsig1(e) + ((e & f) ^ (~e & g)) + K[cnt] + w[0];
    t2_c     = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
    // W[t+16] from the window W[t..t+15]
    w_next_c = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];
  end

  // Control FSM with registered digest and ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= LOAD;
      cnt       <= '0;
      ready     <= 1'b0;
      hashvalue <= '0;
      a <= '0; b <= '0; c <= '0; d <= '0;
      e <= '0; f <= '0; g <= '0; h <= '0;
      for (int i = 0; i < 16; i++) w[i] <= '0;
    end else begin
      case (state)
        LOAD: begin
          for (int i = 0; i < 16; i++) w[i] <= message[32*i +: 32];
          a <= IV[0]; b <= IV[1]; c <= IV[2]; d <= IV[3];
          e <= IV[4]; f <= IV[5]; g <= IV[6]; h <= IV[7];
          cnt   <= '0;
          state <= ROUND;
        end
        ROUND: begin
          a <= t1_c + t2_c; b <= a; c <= b; d <= c;
          e <= d + t1_c;    f <= e; g <= f; h <= g;
          for (int i = 0; i < 15; i++) w[i] <= w[i+1];
          w[15] <= w_next_c;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(63)) state <= DONE;
        end
        DONE: begin
          // First DONE cycle performs the feed-forward add; afterwards hold.
          if (!ready) begin
            hashvalue <= {IV[0] + a, IV[1] + b, IV[2] + c, IV[3] + d,
                          IV[4] + e, IV[5] + f, IV[6] + g, IV[7] + h};
            ready     <= 1'b1;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_overall.sv
`timescale 1ns/1ps
// Self-checking bench for the single-block SHA-256 core: known vectors,
// randomized blocks against a behavioural SHA-256 model, reset behaviour.
module tb_overall;

  logic         clk;
  logic         reset;
  logic [0:511] message;
  logic         ready;
  logic [255:0] hashvalue;

  int total = 0;
  int bad   = 0;

  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_DIGEST =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  localparam logic [31:0] H_INIT [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  overall dut (
    .clk      (clk),
    .reset    (reset),
    .message  (message),
    .ready    (ready),
    .hashvalue(hashvalue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference SHA-256 compression of one block, full 64-word schedule.
  function automatic logic [255:0] sha_ref(input logic [0:511] blk);
    logic [31:0]  w [64];
    logic [31:0]  v [8];
    logic [31:0]  t1, t2, s0, s1;
    logic [255:0] res;
    for (int i = 0; i < 16; i++) w[i] = blk[32*i +: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    for (int i = 0; i < 8; i++) v[i] = H_INIT[i];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
           + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
           + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) res[255-32*i -: 32] = H_INIT[i] + v[i];
    return res;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_abc();
    message = '0;
    message[0:31]    = 32'h61626380;
    message[480:511] = 32'h00000018;
  endtask

  task automatic set_empty();
    message = '0;
    message[0:31] = 32'h80000000;
  endtask

  // Assert reset away from an edge and hold it for n rising edges.
  task automatic hold_reset(input int n, input string tag);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk({tag, "_async_ready"}, 256'(ready), 256'(0));
    chk({tag, "_async_hash"}, hashvalue, 256'(0));
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_ready"}, 256'(ready), 256'(0));
      chk({tag, "_hold_hash"}, hashvalue, 256'(0));
    end
  endtask

  // Release reset at a random clock phase, then watch edges 1..66.
  // stop_at > 0 ends the run early; scramble drives garbage after cycle 0.
  task automatic run_hash(input string tag, input logic [255:0] exp,
                          input int stop_at, input bit scramble);
    int dly;
    int last;
    dly = int'($urandom_range(1, 9));
    @(posedge clk); #(dly);
    reset = 1'b1;
    last = (stop_at > 0) ? stop_at : 66;
    for (int k = 1; k <= last; k++) begin
      @(posedge clk); #1;
      if (scramble) for (int i = 0; i < 16; i++) message[32*i +: 32] = $urandom();
      if (k < 66) begin
        chk({tag, "_busy_ready"}, 256'(ready), 256'(0));
        chk({tag, "_busy_hash"}, hashvalue, 256'(0));
      end else begin
        chk({tag, "_ready"}, 256'(ready), 256'(1));
        chk({tag, "_digest"}, hashvalue, exp);
      end
    end
  endtask

  initial begin
    logic [255:0] exp;
    reset = 1'b0;
    set_abc();

    // Reset state with clock running
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 256'(ready), 256'(0));
    chk("reset_hash", hashvalue, 256'(0));

    // Long reset, then the "abc" vector
    hold_reset(10, "rst10");
    run_hash("abc", ABC_DIGEST, 0, 1'b0);

    // DONE holds while message toggles
    message = '1;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (k == 50) message = '0;
      if (k == 51) message = '1;
      chk("hold_ready", 256'(ready), 256'(1));
      chk("hold_digest", hashvalue, ABC_DIGEST);
    end

    // Abort an "abc" run at edge 30, then hash the empty block
    hold_reset(1, "pre_abort");
    set_abc();
    run_hash("abort_abc", ABC_DIGEST, 30, 1'b0);
    hold_reset(2, "abort");
    set_empty();
    run_hash("empty", EMPTY_DIGEST, 0, 1'b0);

    // Random blocks against the reference model
    for (int n = 0; n < 6; n++) begin
      hold_reset(1 + int'($urandom_range(0, 2)), "rand_rst");
      for (int i = 0; i < 16; i++) message[32*i +: 32] = $urandom();
      exp = sha_ref(message);
      run_hash("rand", exp, 0, n[0]);
    end

    // Model sanity against the known vectors
    set_abc();
    chk("model_abc", sha_ref(message), ABC_DIGEST);
    set_empty();
    chk("model_empty", sha_ref(message), EMPTY_DIGEST);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/overall.md
OVERALL -- requirements
Module: overall

Interface
REQ-001 SHALL have no parameters; block size fixed at 512 bits, digest at 256 bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset is asynchronous and active-low; low clears all state, high allows operation.
REQ-004 SHALL have port message[0:511], input, 512 bits: one pre-padded SHA-256 block; bit 0 is the MSB of word W0, bits [32i:32i+31] form W[i], MSB first.
REQ-005 SHALL have port ready, output, 1 bit: high when hashvalue holds the finished digest.
REQ-006 SHALL have port hashvalue[255:0], output, 256 bits: digest with H0 at [255:224] through H7 at [31:0].

Function
REQ-007 SHALL compute the FIPS 180-4 SHA-256 compression of one block from the standard initial hash values (6a09e667 … 5be0cd19), and add the result to those values mod 2^32 per word.
REQ-008 SHALL NOT perform padding; the block is already padded by the caller.
REQ-009 SHALL, on the first rising clk edge with reset high (cycle 0), latch message into the W schedule, load a..h with H0..H7, and clear the round counter.
REQ-010 SHALL perform one round per cycle on cycles 1..64 using K[t] and W[t]; W[t] for t≥16 = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16] mod 2^32, generated on the fly over a 16-word sliding window.
REQ-011 SHALL perform the final per-word addition on cycle 65, register it into hashvalue, and assert ready at the same edge; ready therefore goes high 66 rising edges after reset is released.
REQ-012 SHALL use a 3-state FSM: LOAD (cycle 0) -> ROUND (64 cycles, counter 0..63) -> DONE; DONE is absorbing until reset is asserted.
REQ-013 SHALL hold ready high and hashvalue constant in DONE regardless of changes on message.
REQ-014 SHALL ignore changes on message after cycle 0; a new hash requires reset low for ≥1 cycle, then release.
REQ-015 SHALL keep ready low and hashvalue at 0 in LOAD and ROUND.
REQ-016 SHALL implement all additions as modulo-2^32 with carry discarded; Σ0/Σ1/σ0/σ1/Ch/Maj exactly as FIPS 180-4.
REQ-017 SHALL hold the 64-entry K table as constants, with no external memory.

Reset
REQ-018 SHALL, while reset is low, force ready=0, hashvalue=0, FSM=LOAD, round counter=0, independent of clk.
REQ-019 SHALL abort any computation in progress when reset goes low mid-operation, with no partial result visible; after release, restart from REQ-009 with the current message.
REQ-020 SHALL produce the same result when reset is released at any clk phase; the first rising edge with reset high is cycle 0.

Verification
REQ-021 "abc" block (W0=61626380, W1..W14=0, W15=00000018), release reset -> ready rises at edge 66; hashvalue=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
REQ-022 Empty-string block (W0=80000000, W1..W15=0) -> hashvalue=e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855 at edge 66.
REQ-023 Reset pulsed low at edge 30 of an "abc" run, message switched to the empty block, reset released -> ready stays 0 during the pulse; the empty-string digest appears 66 edges after release.
REQ-024 After ready=1, message changed to all-ones for 100 cycles -> ready stays 1 and hashvalue is unchanged.
REQ-025 Reset held low for 10 cycles -> ready=0 and hashvalue=0 throughout; ready=0 at edges 1..65 after release.
